// File: rtl/wb_demux_regfile_16bit.sv
// Register file with one write-back port and two combinational read ports.
// Register 0 is hard-wired to zero; reads bypass a same-cycle write to the same index.
module wb_demux_regfile_16bit #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREG   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [2:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [2:0]        rd_addr_a,
    input  logic [2:0]        rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [NREG-1:0]   wr_sel,
    output logic [NREG-1:0]   reg_valid,
    output logic [7:0]        wr_count
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   wr_sel_q, wr_sel_d;
    logic [NREG-1:0]   reg_valid_q, reg_valid_d;
    logic [7:0]        wr_count_q, wr_count_d;
    logic [NREG-1:0]   wr_dec;
    logic              wr_acc;

    // A write is accepted only outside reset and never to the zero register.
    always_comb begin
        wr_acc = we && (wr_addr != 3'd0) && !rst;
        wr_dec = '0;
        wr_dec[wr_addr] = 1'b1;

        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = (wr_acc && wr_dec[i]) ? wr_data : regs_q[i];
        end
        regs_d[0] = '0;

        wr_sel_d    = wr_acc ? wr_dec : wr_sel_q;
        reg_valid_d = wr_acc ? (reg_valid_q | wr_dec) : reg_valid_q;
        reg_valid_d[0] = 1'b1;
        wr_count_d  = wr_acc ? wr_count_q + 8'd1 : wr_count_q;
    end

    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        if (!rst) begin
            rd_data_a = (wr_acc && rd_addr_a == wr_addr) ? wr_data : regs_q[rd_addr_a];
            rd_data_b = (wr_acc && rd_addr_b == wr_addr) ? wr_data : regs_q[rd_addr_b];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            wr_sel_q    <= '0;
            reg_valid_q <= {{(NREG-1){1'b0}}, 1'b1};
            wr_count_q  <= 8'd0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            wr_sel_q    <= wr_sel_d;
            reg_valid_q <= reg_valid_d;
            wr_count_q  <= wr_count_d;
        end
    end

    assign wr_sel    = wr_sel_q;
    assign reg_valid = reg_valid_q;
    assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_wb_demux_regfile_16bit.sv
// Self-checking bench for wb_demux_regfile_16bit: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_wb_demux_regfile_16bit;

    logic        clk;
    logic        rst;
    logic        we;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic [7:0]  wr_sel;
    logic [7:0]  reg_valid;
    logic [7:0]  wr_count;

    int errors = 0;
    int checks = 0;

    logic [15:0] m_regs [8];
    logic [7:0]  m_valid;
    logic [7:0]  m_sel;
    int          m_count;

    wb_demux_regfile_16bit #(
        .DATA_W(16),
        .NREG  (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr_a(rd_addr_a),
        .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a),
        .rd_data_b(rd_data_b),
        .wr_sel   (wr_sel),
        .reg_valid(reg_valid),
        .wr_count (wr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        m_valid = 8'h01;
        m_sel   = 8'h00;
        m_count = 0;
    endtask

    // Expected read value from the architectural rules, given current inputs.
    function automatic logic [15:0] exp_read(input logic [2:0] a);
        if (rst) return 16'h0000;
        if (we && wr_addr != 3'd0 && a == wr_addr) return wr_data;
        return m_regs[a];
    endfunction

    // Apply the current inputs to the model, then advance past the next rising edge.
    task automatic step();
        if (we && wr_addr != 3'd0 && !rst) begin
            m_regs[wr_addr]  = wr_data;
            m_valid[wr_addr] = 1'b1;
            m_sel            = 8'h01 << wr_addr;
            m_count          = (m_count + 1) % 256;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [15:0] d);
        we      = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        we      = 1'b0;
    endtask

    task automatic apply_reset();
        we  = 1'b0;
        rst = 1'b1;
        #3;
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; we = 1'b1; wr_addr = 3'd3; wr_data = 16'h5A5A;
        rd_addr_a = 3'd3; rd_addr_b = 3'd0;
        #1;
        checks++; if (rd_data_a !== 16'h0000) begin errors++;
            $display("FAIL reset_rd_a: got %h expected 0000", rd_data_a); end
        checks++; if (reg_valid !== 8'h01) begin errors++;
            $display("FAIL reset_valid: got %h expected 01", reg_valid); end
        checks++; if (wr_sel !== 8'h00) begin errors++;
            $display("FAIL reset_sel: got %h expected 00", wr_sel); end
        checks++; if (wr_count !== 8'h00) begin errors++;
            $display("FAIL reset_count: got %h expected 00", wr_count); end
        @(posedge clk);
        #1;
        checks++; if (wr_count !== 8'h00 || reg_valid !== 8'h01) begin errors++;
            $display("FAIL reset_write_ignored: got count=%h valid=%h expected 00/01",
                     wr_count, reg_valid); end
        rst = 1'b0; we = 1'b0;
        model_reset();
        #1;
        checks++; if (rd_data_a !== 16'h0000) begin errors++;
            $display("FAIL reset_no_store: got %h expected 0000", rd_data_a); end
    endtask

    task automatic test_basic_write();
        do_write(3'd3, 16'hBEEF);
        rd_addr_a = 3'd3;
        #1;
        checks++; if (rd_data_a !== 16'hBEEF) begin errors++;
            $display("FAIL basic_rd: got %h expected BEEF", rd_data_a); end
        checks++; if (wr_sel !== 8'h08) begin errors++;
            $display("FAIL basic_sel: got %h expected 08", wr_sel); end
        checks++; if (reg_valid !== 8'h09) begin errors++;
            $display("FAIL basic_valid: got %h expected 09", reg_valid); end
        checks++; if (wr_count !== 8'd1) begin errors++;
            $display("FAIL basic_count: got %0d expected 1", wr_count); end
    endtask

    task automatic test_zero_write();
        we = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF;
        rd_addr_a = 3'd0; rd_addr_b = 3'd0;
        #1;
        checks++; if (rd_data_a !== 16'h0000 || rd_data_b !== 16'h0000) begin errors++;
            $display("FAIL zero_pre: got a=%h b=%h expected 0000", rd_data_a, rd_data_b); end
        step();
        we = 1'b0;
        checks++; if (rd_data_a !== 16'h0000 || rd_data_b !== 16'h0000) begin errors++;
            $display("FAIL zero_post: got a=%h b=%h expected 0000", rd_data_a, rd_data_b); end
        checks++; if (wr_count !== 8'd1 || wr_sel !== 8'h08 || reg_valid !== 8'h09) begin
            errors++;
            $display("FAIL zero_state: got count=%h sel=%h valid=%h expected 01/08/09",
                     wr_count, wr_sel, reg_valid); end
    endtask

    task automatic test_bypass();
        do_write(3'd5, 16'h1111);
        we = 1'b1; wr_addr = 3'd5; wr_data = 16'h2222;
        rd_addr_a = 3'd5; rd_addr_b = 3'd5;
        #1;
        checks++; if (rd_data_a !== 16'h2222 || rd_data_b !== 16'h2222) begin errors++;
            $display("FAIL bypass_pre: got a=%h b=%h expected 2222", rd_data_a, rd_data_b); end
        step();
        we = 1'b0;
        #1;
        checks++; if (rd_data_a !== 16'h2222 || rd_data_b !== 16'h2222) begin errors++;
            $display("FAIL bypass_post: got a=%h b=%h expected 2222", rd_data_a, rd_data_b); end
    endtask

    task automatic test_all_pairs();
        for (int i = 1; i < 8; i++) do_write(3'(i), 16'(i * 16'h0101));
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                rd_addr_a = 3'(a);
                rd_addr_b = 3'(b);
                #1;
                checks++; if (rd_data_a !== 16'(a * 16'h0101)) begin errors++;
                    $display("FAIL pairs_a[%0d,%0d]: got %h expected %h", a, b, rd_data_a,
                             16'(a * 16'h0101)); end
                checks++; if (rd_data_b !== 16'(b * 16'h0101)) begin errors++;
                    $display("FAIL pairs_b[%0d,%0d]: got %h expected %h", a, b, rd_data_b,
                             16'(b * 16'h0101)); end
            end
        end
        checks++; if (reg_valid !== 8'hFF) begin errors++;
            $display("FAIL pairs_valid: got %h expected FF", reg_valid); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            we        = ($urandom_range(0, 3) != 0);
            wr_addr   = 3'($urandom_range(0, 7));
            wr_data   = 16'($urandom);
            rd_addr_a = ($urandom_range(0, 2) == 0) ? wr_addr : 3'($urandom_range(0, 7));
            rd_addr_b = ($urandom_range(0, 2) == 0) ? wr_addr : 3'($urandom_range(0, 7));
            #1;
            checks++; if (rd_data_a !== exp_read(rd_addr_a)) begin errors++;
                $display("FAIL rand_rd_a[%0d]: got %h expected %h", n, rd_data_a,
                         exp_read(rd_addr_a)); end
            checks++; if (rd_data_b !== exp_read(rd_addr_b)) begin errors++;
                $display("FAIL rand_rd_b[%0d]: got %h expected %h", n, rd_data_b,
                         exp_read(rd_addr_b)); end
            step();
            checks++; if (wr_sel !== m_sel || reg_valid !== m_valid ||
                          wr_count !== 8'(m_count)) begin errors++;
                $display("FAIL rand_state[%0d]: got sel=%h valid=%h count=%h expected %h/%h/%h",
                         n, wr_sel, reg_valid, wr_count, m_sel, m_valid, 8'(m_count)); end
        end
        we = 1'b0;
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int n = 0; n < 256; n++) do_write(3'($urandom_range(1, 7)), 16'($urandom));
        checks++; if (wr_count !== 8'd0) begin errors++;
            $display("FAIL wrap_256: got %0d expected 0", wr_count); end
        do_write(3'd7, 16'h0F0F);
        checks++; if (wr_count !== 8'd1) begin errors++;
            $display("FAIL wrap_257: got %0d expected 1", wr_count); end
    endtask

    task automatic test_async_reset();
        do_write(3'd6, 16'hA5A5);
        do_write(3'd2, 16'h1234);
        we = 1'b1; wr_addr = 3'd4; wr_data = 16'hDEAD;
        rd_addr_a = 3'd4; rd_addr_b = 3'd6;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (rd_data_a !== 16'h0000 || rd_data_b !== 16'h0000) begin errors++;
            $display("FAIL areset_rd: got a=%h b=%h expected 0000", rd_data_a, rd_data_b); end
        checks++; if (reg_valid !== 8'h01 || wr_sel !== 8'h00 || wr_count !== 8'h00) begin
            errors++;
            $display("FAIL areset_state: got valid=%h sel=%h count=%h expected 01/00/00",
                     reg_valid, wr_sel, wr_count); end
        model_reset();
        @(posedge clk);
        #1;
        checks++; if (reg_valid !== 8'h01 || wr_count !== 8'h00) begin errors++;
            $display("FAIL areset_hold: got valid=%h count=%h expected 01/00",
                     reg_valid, wr_count); end
        rst = 1'b0;
        #1;
        checks++; if (rd_data_a !== 16'hDEAD || rd_data_b !== 16'h0000) begin errors++;
            $display("FAIL areset_release_rd: got a=%h b=%h expected DEAD/0000",
                     rd_data_a, rd_data_b); end
        step();
        we = 1'b0;
        checks++; if (reg_valid !== 8'h11 || wr_sel !== 8'h10 || wr_count !== 8'd1) begin
            errors++;
            $display("FAIL areset_first_write: got valid=%h sel=%h count=%h expected 11/10/01",
                     reg_valid, wr_sel, wr_count); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_write();
        test_zero_write();
        test_bypass();
        test_all_pairs();
        test_random();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
